// File: rtl/fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared types and default constants for the instruction-fetch controller.
//   fetchState_t   : 2-bit fetch sequencer state (BOOT / RUN / MISS / REFILL)
//   PC_SIZE_DEF    : default PC / address width
//   INSTR_SIZE     : instruction word width
//   RESET_VEC_DEF  : default first fetch address after reset
//   LINE_WORDS_DEF : default number of 32-bit words per icache line
//   PC_STEP        : byte increment between sequential fetches
// ----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int          PC_SIZE_DEF    = 32;
    localparam int          INSTR_SIZE     = 32;
    localparam logic [31:0] RESET_VEC_DEF  = 32'h0000_0000;
    localparam int          LINE_WORDS_DEF = 4;
    localparam int          PC_STEP        = 4;

    typedef enum logic [1:0] {
        FC_BOOT   = 2'b00,
        FC_RUN    = 2'b01,
        FC_MISS   = 2'b10,
        FC_REFILL = 2'b11
    } fetchState_t;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_refill_fsm.sv
// ----------------------------------------------------------------------------
// fetch_refill_fsm
// Fetch sequencer state machine. It owns the BOOT/RUN/MISS/REFILL states, the
// refill request handshake and the beat counter that addresses icache writes.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   i_icHit          : icache hit for the current fetch PC
//   i_exRedirect     : EX redirect (a redirect in RUN suppresses a miss)
//   i_refillAck      : memory accepted the refill request
//   i_refillValid    : one refill data beat is present
//   o_state          : current sequencer state
//   o_refillReq      : refill request, held until acknowledged
//   o_icWrEn         : write the present beat into the icache
//   o_icWrIdx        : word index of the present beat
//   o_refillDone     : final beat of the line is being written this cycle
//   o_missStart      : RUN is leaving for MISS at the next edge
// ----------------------------------------------------------------------------
module fetch_refill_fsm
    import fetch_ctrl_pkg::*;
#(
    parameter  int LINE_WORDS = LINE_WORDS_DEF,
    localparam int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_icHit,
    input  logic             i_exRedirect,
    input  logic             i_refillAck,
    input  logic             i_refillValid,
    output fetchState_t      o_state,
    output logic             o_refillReq,
    output logic             o_icWrEn,
    output logic [IDX_W-1:0] o_icWrIdx,
    output logic             o_refillDone,
    output logic             o_missStart
);

    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(LINE_WORDS - 1);

    fetchState_t      r_state;
    fetchState_t      w_nextState;
    logic [IDX_W-1:0] r_beatCnt;
    logic             w_lastBeat;

    assign w_lastBeat = (r_beatCnt == LAST_BEAT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FC_BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Beat counter: cleared when the request is accepted, stepped per beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beatCnt <= '0;
        end else if (r_state == FC_MISS && i_refillAck) begin
            r_beatCnt <= '0;
        end else if (r_state == FC_REFILL && i_refillValid) begin
            r_beatCnt <= r_beatCnt + IDX_W'(1);
        end
    end

    // Next-state logic; a redirect in RUN takes precedence over a miss
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            FC_BOOT:   w_nextState = FC_RUN;
            FC_RUN:    if (!i_exRedirect && !i_icHit) w_nextState = FC_MISS;
            FC_MISS:   if (i_refillAck) w_nextState = FC_REFILL;
            FC_REFILL: if (i_refillValid && w_lastBeat) w_nextState = FC_RUN;
            default:   w_nextState = FC_BOOT;
        endcase
    end

    // Output decode
    always_comb begin
        o_refillReq  = 1'b0;
        o_icWrEn     = 1'b0;
        o_refillDone = 1'b0;
        o_missStart  = 1'b0;
        case (r_state)
            FC_RUN:    o_missStart  = !i_exRedirect && !i_icHit;
            FC_MISS:   o_refillReq  = 1'b1;
            FC_REFILL: begin
                o_icWrEn     = i_refillValid;
                o_refillDone = i_refillValid && w_lastBeat;
            end
            default:   ;
        endcase
    end

    assign o_state   = r_state;
    assign o_icWrIdx = r_beatCnt;

endmodule : fetch_refill_fsm

// File: rtl/fetch_ctrl.sv
// ----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch scheduler: picks the next PC each cycle, enables the
// icache and drives the icache-miss refill handshake toward memory.
// Optional build macro: FETCH_PERF_CNT_EN adds saturating miss/redirect
// counters on perf_miss_cnt / perf_redir_cnt.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   ld_stall      : load-use stall, hold PC (RUN only)
//   ex_redirect   : EX redirect request, target on ex_pc
//   pd_take       : predecode predicts taken, target on pd_target
//   ic_hit        : icache hit for pc_out
//   ic_en         : icache read enable
//   pc_out        : current fetch PC
//   if_valid      : instruction at pc_out is valid for decode
//   refill_req    : line refill request, refill_addr is line aligned
//   refill_ack    : memory accepted the request
//   refill_valid  : one refill data beat present
//   ic_wr_en      : write current beat into icache at word ic_wr_idx
// ----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter  int                 PC_SIZE    = PC_SIZE_DEF,
    parameter  logic [PC_SIZE-1:0] RESET_VEC  = PC_SIZE'(RESET_VEC_DEF),
    parameter  int                 LINE_WORDS = LINE_WORDS_DEF,
    localparam int                 IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_stall,
    input  logic               ex_redirect,
    input  logic [PC_SIZE-1:0] ex_pc,
    input  logic               pd_take,
    input  logic [PC_SIZE-1:0] pd_target,
    input  logic               ic_hit,
    output logic               ic_en,
    output logic [PC_SIZE-1:0] pc_out,
    output logic               if_valid,
    output logic               refill_req,
    output logic [PC_SIZE-1:0] refill_addr,
    input  logic               refill_ack,
    input  logic               refill_valid,
    output logic               ic_wr_en,
`ifdef FETCH_PERF_CNT_EN
    output logic [IDX_W-1:0]   ic_wr_idx,
    output logic [31:0]        perf_miss_cnt,
    output logic [31:0]        perf_redir_cnt
`else
    output logic [IDX_W-1:0]   ic_wr_idx
`endif
);

    localparam int                 OFFSET_BITS = $clog2(LINE_WORDS * 4);
    localparam logic [PC_SIZE-1:0] LINE_MASK   = ~((PC_SIZE'(1) << OFFSET_BITS) - PC_SIZE'(1));

    fetchState_t        w_state;
    logic               w_refillDone;
    logic               w_missStart;
    logic               w_inRun;
    logic               w_inRefillPath;
    logic [PC_SIZE-1:0] r_pc;
    logic [PC_SIZE-1:0] w_nextPc;
    logic               r_redirPend;
    logic [PC_SIZE-1:0] r_redirPc;
    logic               w_pendNow;
    logic [PC_SIZE-1:0] w_pendTarget;

    fetch_refill_fsm #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refillFsm (
        .clk           (clk),
        .rst           (rst),
        .i_icHit       (ic_hit),
        .i_exRedirect  (ex_redirect),
        .i_refillAck   (refill_ack),
        .i_refillValid (refill_valid),
        .o_state       (w_state),
        .o_refillReq   (refill_req),
        .o_icWrEn      (ic_wr_en),
        .o_icWrIdx     (ic_wr_idx),
        .o_refillDone  (w_refillDone),
        .o_missStart   (w_missStart)
    );

    assign w_inRun        = (w_state == FC_RUN);
    assign w_inRefillPath = (w_state == FC_MISS) || (w_state == FC_REFILL);

    // A redirect arriving on the final refill beat must still win over any
    // target latched earlier, so the latch is bypassed in that cycle.
    assign w_pendNow    = r_redirPend || ex_redirect;
    assign w_pendTarget = ex_redirect ? ex_pc : r_redirPc;

    // Next-PC selection. Outside RUN the PC only moves when a refill that
    // saw a redirect completes.
    always_comb begin
        w_nextPc = r_pc;
        if (w_inRun) begin
            if (ex_redirect) begin
                w_nextPc = ex_pc;
            end else if (ld_stall || !ic_hit) begin
                w_nextPc = r_pc;
            end else if (pd_take) begin
                w_nextPc = pd_target;
            end else begin
                w_nextPc = r_pc + PC_SIZE'(PC_STEP);
            end
        end else if (w_refillDone && w_pendNow) begin
            w_nextPc = w_pendTarget;
        end
    end

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_nextPc;
        end
    end

    // Redirects seen while the line is being fetched are parked here until
    // the refill completes; the newest redirect overwrites older ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirPend <= 1'b0;
            r_redirPc   <= '0;
        end else if (w_refillDone) begin
            r_redirPend <= 1'b0;
        end else if (w_inRefillPath && ex_redirect) begin
            r_redirPend <= 1'b1;
            r_redirPc   <= ex_pc;
        end
    end

    assign pc_out      = r_pc;
    assign ic_en       = w_inRun;
    assign if_valid    = w_inRun && ic_hit && !ld_stall && !ex_redirect;
    assign refill_addr = refill_req ? (r_pc & LINE_MASK) : '0;

`ifdef FETCH_PERF_CNT_EN
    logic w_redirAccepted;

    assign w_redirAccepted = ex_redirect && (w_inRun || w_inRefillPath);

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_miss_cnt  <= '0;
            perf_redir_cnt <= '0;
        end else begin
            if (w_missStart && perf_miss_cnt != 32'hFFFF_FFFF) begin
                perf_miss_cnt <= perf_miss_cnt + 32'd1;
            end
            if (w_redirAccepted && perf_redir_cnt != 32'hFFFF_FFFF) begin
                perf_redir_cnt <= perf_redir_cnt + 32'd1;
            end
        end
    end
`endif

endmodule : fetch_ctrl

// File: tb/tb_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed self-checking bench for fetch_ctrl: boot, sequential fetch, miss
// handshake and refill beats, redirect priority, stalls, PC wrap, redirects
// parked during refill and reset in the middle of a refill.
// ----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        ld_stall;
    logic        ex_redirect;
    logic [31:0] ex_pc;
    logic        pd_take;
    logic [31:0] pd_target;
    logic        ic_hit;
    logic        ic_en;
    logic [31:0] pc_out;
    logic        if_valid;
    logic        refill_req;
    logic [31:0] refill_addr;
    logic        refill_ack;
    logic        refill_valid;
    logic        ic_wr_en;
    logic [1:0]  ic_wr_idx;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_miss_cnt;
    logic [31:0] perf_redir_cnt;
`endif

    int nChecks = 0;
    int nFails  = 0;

    fetch_ctrl #(
        .PC_SIZE    (32),
        .RESET_VEC  (32'h0000_0000),
        .LINE_WORDS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_stall     (ld_stall),
        .ex_redirect  (ex_redirect),
        .ex_pc        (ex_pc),
        .pd_take      (pd_take),
        .pd_target    (pd_target),
        .ic_hit       (ic_hit),
        .ic_en        (ic_en),
        .pc_out       (pc_out),
        .if_valid     (if_valid),
        .refill_req   (refill_req),
        .refill_addr  (refill_addr),
        .refill_ack   (refill_ack),
        .refill_valid (refill_valid),
        .ic_wr_en     (ic_wr_en),
`ifdef FETCH_PERF_CNT_EN
        .ic_wr_idx      (ic_wr_idx),
        .perf_miss_cnt  (perf_miss_cnt),
        .perf_redir_cnt (perf_redir_cnt)
`else
        .ic_wr_idx    (ic_wr_idx)
`endif
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every input for the current cycle and let combinational outputs settle
    task automatic applyStimulus(input logic ldStall, input logic exRedir,
                                 input logic [31:0] exPc, input logic pdTake,
                                 input logic [31:0] pdTarget, input logic icHit,
                                 input logic ack, input logic beatValid);
        ld_stall     = ldStall;
        ex_redirect  = exRedir;
        ex_pc        = exPc;
        pd_take      = pdTake;
        pd_target    = pdTarget;
        ic_hit       = icHit;
        refill_ack   = ack;
        refill_valid = beatValid;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nChecks++;
        assert (observed === expected)
        else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        tick();
        tick();

        // Reset values
        checkOutput("rst_pc", pc_out, 32'h0);
        checkOutput("rst_ic_en", 32'(ic_en), 32'h0);
        checkOutput("rst_if_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_refill_req", 32'(refill_req), 32'h0);
        checkOutput("rst_ic_wr_en", 32'(ic_wr_en), 32'h0);

        // Boot then sequential fetch
        rst = 1'b0;
        #1;
        checkOutput("boot_ic_en", 32'(ic_en), 32'h0);
        checkOutput("boot_if_valid", 32'(if_valid), 32'h0);
        tick();
        checkOutput("seq0_pc", pc_out, 32'h0);
        checkOutput("seq0_if_valid", 32'(if_valid), 32'h1);
        checkOutput("seq0_ic_en", 32'(ic_en), 32'h1);
        tick();
        checkOutput("seq1_pc", pc_out, 32'h4);
        checkOutput("seq1_if_valid", 32'(if_valid), 32'h1);
        tick();
        checkOutput("seq2_pc", pc_out, 32'h8);
        checkOutput("seq2_if_valid", 32'(if_valid), 32'h1);
        tick();
        tick();
        checkOutput("seq4_pc", pc_out, 32'h10);

        // Miss at 0x10, request held three cycles before ack
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        checkOutput("miss_if_valid", 32'(if_valid), 32'h0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("miss_req_c1", 32'(refill_req), 32'h1);
        checkOutput("miss_addr", refill_addr, 32'h10);
        checkOutput("miss_ic_en", 32'(ic_en), 32'h0);
        checkOutput("miss_if_valid_hit", 32'(if_valid), 32'h0);
        tick();
        checkOutput("miss_req_c2", 32'(refill_req), 32'h1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 1, 0);
        checkOutput("miss_req_c3", 32'(refill_req), 32'h1);
        tick();

        // Four beats with a gap after the first
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
        checkOutput("refill_req_low", 32'(refill_req), 32'h0);
        checkOutput("beat0_wr_en", 32'(ic_wr_en), 32'h1);
        checkOutput("beat0_idx", 32'(ic_wr_idx), 32'h0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("gap_wr_en", 32'(ic_wr_en), 32'h0);
        tick();
        for (int b = 1; b < 4; b++) begin
            applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
            checkOutput("beat_wr_en", 32'(ic_wr_en), 32'h1);
            checkOutput("beat_idx", 32'(ic_wr_idx), 32'(b));
            tick();
        end
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("refetch_pc", pc_out, 32'h10);
        checkOutput("refetch_if_valid", 32'(if_valid), 32'h1);
        checkOutput("refetch_ic_en", 32'(ic_en), 32'h1);

        // Advance 0x10 -> 0x20
        for (int k = 0; k < 4; k++) tick();
        checkOutput("seq_pc_20", pc_out, 32'h20);

        // Redirect beats predecode take in the same cycle
        applyStimulus(0, 1, 32'h40, 1, 32'h100, 1, 0, 0);
        checkOutput("redir_if_valid", 32'(if_valid), 32'h0);
        tick();
        checkOutput("redir_pc", pc_out, 32'h40);

        // Predecode take alone
        applyStimulus(0, 0, 32'h0, 1, 32'h100, 1, 0, 0);
        checkOutput("pd_if_valid", 32'(if_valid), 32'h1);
        tick();
        checkOutput("pd_pc", pc_out, 32'h100);

        // Load-use stall at 0x30
        applyStimulus(0, 1, 32'h30, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(1, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("stall1_pc", pc_out, 32'h30);
        checkOutput("stall1_if_valid", 32'(if_valid), 32'h0);
        tick();
        checkOutput("stall2_pc", pc_out, 32'h30);
        checkOutput("stall2_if_valid", 32'(if_valid), 32'h0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("unstall_pc", pc_out, 32'h30);
        checkOutput("unstall_if_valid", 32'(if_valid), 32'h1);
        tick();
        checkOutput("unstall_adv_pc", pc_out, 32'h34);

        // Redirect wins over a same-cycle stall
        applyStimulus(1, 1, 32'h80, 0, 32'h0, 1, 0, 0);
        tick();
        checkOutput("redir_stall_pc", pc_out, 32'h80);

        // Miss at an unaligned word, redirect during beat 1
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 1, 0);
        checkOutput("miss2_addr", refill_addr, 32'h80);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
        tick();
        applyStimulus(0, 1, 32'h200, 0, 32'h0, 1, 0, 1);
        checkOutput("rr_beat1_idx", 32'(ic_wr_idx), 32'h1);
        checkOutput("rr_beat1_if_valid", 32'(if_valid), 32'h0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
        checkOutput("rr_beat2_pc", pc_out, 32'h84);
        checkOutput("rr_beat2_idx", 32'(ic_wr_idx), 32'h2);
        tick();
        checkOutput("rr_beat3_idx", 32'(ic_wr_idx), 32'h3);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("rr_pc", pc_out, 32'h200);

        // A later parked redirect overwrites an earlier one
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 1, 32'h500, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 1, 0);
        tick();
        applyStimulus(0, 1, 32'h600, 0, 32'h0, 1, 0, 1);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
        tick();
        tick();
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("overwrite_pc", pc_out, 32'h600);

        // PC wrap
        applyStimulus(0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("wrap_pre_pc", pc_out, 32'hFFFF_FFFC);
        tick();
        checkOutput("wrap_pc", pc_out, 32'h0);

        // Reset in the middle of a refill at 0x1000
        applyStimulus(0, 1, 32'h1000, 0, 32'h0, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 1, 0);
        checkOutput("miss3_addr", refill_addr, 32'h1000);
        tick();
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 1);
        checkOutput("pre_abort_wr_en", 32'(ic_wr_en), 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("abort_pc", pc_out, 32'h0);
        checkOutput("abort_refill_req", 32'(refill_req), 32'h0);
        checkOutput("abort_wr_en", 32'(ic_wr_en), 32'h0);
        checkOutput("abort_ic_en", 32'(ic_en), 32'h0);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("abort_perf_miss", perf_miss_cnt, 32'h0);
        checkOutput("abort_perf_redir", perf_redir_cnt, 32'h0);
`endif
        tick();
        rst = 1'b0;
        applyStimulus(0, 0, 32'h0, 0, 32'h0, 1, 0, 0);
        checkOutput("reboot_ic_en", 32'(ic_en), 32'h0);
        tick();
        checkOutput("reboot_pc", pc_out, 32'h0);
        checkOutput("reboot_if_valid", 32'(if_valid), 32'h1);
        tick();
        checkOutput("reboot_adv_pc", pc_out, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    // Watchdog against a stalled run
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule : tb_fetch_ctrl
